// File: rtl/ram_port_b_arbiter_pkg.sv
// Shared encodings, defaults and the round-robin pick rule for the RAM port B arbiter.
package ram_port_b_arbiter_pkg;

  localparam int unsigned RamAddrW = 8;
  localparam int unsigned RamDataW = 16;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StAccess = 1'b1
  } arb_state_e;

  typedef enum logic [0:0] {
    MidCpu    = 1'b0,
    MidLoader = 1'b1
  } master_id_e;

  // On a tie the master that did not win last time goes next.
  function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
    logic id;
    case (req)
      2'b01:   id = MidCpu;
      2'b10:   id = MidLoader;
      2'b11:   id = ~last_grant;
      default: id = last_grant;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/ram_port_b_arbiter_rr_arb2.sv
// Two-input round-robin picker; the last-grant history lives in the parent.
module ram_port_b_arbiter_rr_arb2
  import ram_port_b_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  assign gnt_valid = |req;
  assign gnt_id    = rr_pick(req, last_grant);

endmodule

// File: rtl/ram_port_b_arbiter.sv
// Shares RAM port B between the CPU (m0) and the loader (m1). A winning command is registered,
// given one RAM cycle, and answered with a one-cycle ack carrying registered read data.
module ram_port_b_arbiter
  import ram_port_b_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = RamAddrW,
  parameter int unsigned DATA_W = RamDataW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              grant_id
);

  arb_state_e        state_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  master_id_e        grant_q;
  master_id_e        last_grant_q;
  logic              m0_ack_q;
  logic              m1_ack_q;
  logic [DATA_W-1:0] m0_rdata_q;
  logic [DATA_W-1:0] m1_rdata_q;

  logic              gnt_valid;
  logic              gnt_id;
  logic              cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_d;

  ram_port_b_arbiter_rr_arb2 u_rr_arb2 (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    cmd_we_d    = m0_we;
    cmd_addr_d  = m0_addr;
    cmd_wdata_d = m0_wdata;
    if (gnt_id == MidLoader) begin
      cmd_we_d    = m1_we;
      cmd_addr_d  = m1_addr;
      cmd_wdata_d = m1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      grant_q      <= MidCpu;
      last_grant_q <= MidLoader;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (gnt_valid) begin
            we_q         <= cmd_we_d;
            addr_q       <= cmd_addr_d;
            wdata_q      <= cmd_wdata_d;
            grant_q      <= master_id_e'(gnt_id);
            last_grant_q <= master_id_e'(gnt_id);
            state_q      <= StAccess;
          end
        end
        StAccess: begin
          // Writes leave the winner's read-data register untouched.
          if (grant_q == MidLoader) begin
            m1_ack_q <= 1'b1;
            if (!we_q) m1_rdata_q <= ram_rdata;
          end else begin
            m0_ack_q <= 1'b1;
            if (!we_q) m0_rdata_q <= ram_rdata;
          end
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy      = (state_q == StAccess);
  // Reset landing mid-access must not let the write commit.
  assign ram_we    = busy & we_q & ~rst;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign grant_id  = grant_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_ram_port_b_arbiter.sv
// Bench for ram_port_b_arbiter: behavioural 256x16 RAM on port B, per-scenario tasks with a
// queue scoreboard of expected read data and ack cycles.
module tb_ram_port_b_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          busy, grant_id;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  logic          load;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];
  int            cyc_q[$];
  int            id_q[$];
  logic [DW-1:0] m1_last_rd;

  always #5 clk = ~clk;

  ram_port_b_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_ack    (m0_ack),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_ack    (m1_ack),
    .m1_rdata  (m1_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  function automatic logic [DW-1:0] pat(input logic [7:0] a);
    return (a == 8'h80) ? 16'h000A : {8'h5A ^ a, a};
  endfunction

  assign ram_rdata = mem[ram_addr];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i[7:0]);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({m0_ack, m1_ack, busy, grant_id, ram_we} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl got %b want 00000", {m0_ack, m1_ack, busy, grant_id, ram_we});
    end
    n_vec++;
    if (ram_addr !== '0 || ram_wdata !== '0) begin
      n_err++;
      $display("FAIL reset_ram got addr=%h wdata=%h want 0/0", ram_addr, ram_wdata);
    end
    n_vec++;
    if (m0_rdata !== '0 || m1_rdata !== '0) begin
      n_err++;
      $display("FAIL reset_rdata got m0=%h m1=%h want 0/0", m0_rdata, m1_rdata);
    end
    m1_last_rd = '0;
    rst = 0;
  endtask

  task automatic test_single_read();
    logic seen = 0;
    logic [DW-1:0] e;
    int ec;
    m0_req = 1; m0_we = 0; m0_addr = 8'h80;
    exp_q.push_back(ref_mem[8'h80]); cyc_q.push_back(2);
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge clk);
      n_vec++;
      if (m1_ack !== 1'b0) begin n_err++; $display("FAIL single_m1_ack got %b want 0", m1_ack); end
      if (k == 1) begin
        n_vec++;
        if (busy !== 1'b1 || grant_id !== 1'b0) begin
          n_err++; $display("FAIL single_busy got busy=%b gid=%b want 1/0", busy, grant_id);
        end
      end
      if (m0_ack === 1'b1) begin
        seen = 1; m0_req = 0;
        e = exp_q.pop_front(); ec = cyc_q.pop_front();
        n_vec++;
        if (m0_rdata !== e) begin n_err++; $display("FAIL single_rdata got %h want %h", m0_rdata, e); end
        n_vec++;
        if (k != ec) begin n_err++; $display("FAIL single_latency got %0d want %0d", k, ec); end
      end
    end
    if (!seen) begin n_vec++; n_err++; $display("FAIL single_timeout got no m0_ack want ack"); end
    m0_req = 0;
    @(negedge clk);
  endtask

  task automatic test_write_then_read();
    logic seen = 0;
    int we_cnt = 0;
    logic [DW-1:0] e;
    m1_req = 1; m1_we = 1; m1_addr = 8'hFF; m1_wdata = 16'h1234;
    ref_mem[8'hFF] = 16'h1234;
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge clk);
      if (ram_we === 1'b1) begin
        we_cnt++;
        n_vec++;
        if (ram_addr !== 8'hFF || ram_wdata !== 16'h1234) begin
          n_err++; $display("FAIL wr_bus got %h/%h want ff/1234", ram_addr, ram_wdata);
        end
      end
      if (m1_ack === 1'b1) begin
        seen = 1; m1_req = 0;
        n_vec++;
        if (m1_rdata !== m1_last_rd) begin
          n_err++; $display("FAIL wr_rdata_kept got %h want %h", m1_rdata, m1_last_rd);
        end
        n_vec++;
        if (k != 2) begin n_err++; $display("FAIL wr_latency got %0d want 2", k); end
      end
    end
    if (!seen) begin n_vec++; n_err++; $display("FAIL wr_timeout got no m1_ack want ack"); end
    n_vec++;
    if (we_cnt != 1) begin n_err++; $display("FAIL wr_we_cycles got %0d want 1", we_cnt); end
    m1_req = 0; m1_we = 0;
    seen = 0;
    m0_req = 1; m0_we = 0; m0_addr = 8'hFF;
    exp_q.push_back(ref_mem[8'hFF]);
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge clk);
      if (m0_ack === 1'b1) begin
        seen = 1; m0_req = 0;
        e = exp_q.pop_front();
        n_vec++;
        if (m0_rdata !== e) begin n_err++; $display("FAIL raw_rdata got %h want %h", m0_rdata, e); end
      end
    end
    if (!seen) begin n_vec++; n_err++; $display("FAIL raw_timeout got no m0_ack want ack"); end
    m0_req = 0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int acks = 0;
    int id, ec, got_id;
    logic [DW-1:0] e, got;
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    m0_req = 1; m0_addr = 8'h20;
    m1_req = 1; m1_addr = 8'h21;
    for (int i = 0; i < 4; i++) begin
      id_q.push_back(i % 2);
      exp_q.push_back((i % 2) ? ref_mem[8'h21] : ref_mem[8'h20]);
      cyc_q.push_back(2 * (i + 1));
    end
    for (int k = 1; k <= 14 && acks < 4; k++) begin
      @(negedge clk);
      n_vec++;
      if (busy !== ((k % 2) == 1)) begin
        n_err++; $display("FAIL rr_busy k=%0d got %b want %b", k, busy, (k % 2) == 1);
      end
      if ((k % 2) == 1) begin
        n_vec++;
        if (grant_id !== 1'(id_q[0])) begin
          n_err++; $display("FAIL rr_grant k=%0d got %b want %0d", k, grant_id, id_q[0]);
        end
      end
      n_vec++;
      if (m0_ack === 1'b1 && m1_ack === 1'b1) begin
        n_err++; $display("FAIL rr_both_ack got 11 want at most one");
      end
      if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
        acks++;
        id = id_q.pop_front(); e = exp_q.pop_front(); ec = cyc_q.pop_front();
        got_id = (m1_ack === 1'b1) ? 1 : 0;
        got = got_id ? m1_rdata : m0_rdata;
        n_vec++;
        if (got_id != id) begin n_err++; $display("FAIL rr_order got m%0d want m%0d", got_id, id); end
        n_vec++;
        if (got !== e) begin n_err++; $display("FAIL rr_rdata got %h want %h", got, e); end
        n_vec++;
        if (k != ec) begin n_err++; $display("FAIL rr_cycle got %0d want %0d", k, ec); end
        if (acks == 4) begin m0_req = 0; m1_req = 0; end
      end
    end
    if (acks != 4) begin n_vec++; n_err++; $display("FAIL rr_timeout got %0d acks want 4", acks); end
    idle_inputs();
    id_q.delete(); exp_q.delete(); cyc_q.delete();
    m1_last_rd = ref_mem[8'h21];
    repeat (2) begin
      @(negedge clk);
      n_vec++;
      if ({m0_ack, m1_ack, busy} !== 3'b0) begin
        n_err++; $display("FAIL rr_quiet got %b want 000", {m0_ack, m1_ack, busy});
      end
    end
  endtask

  task automatic test_hold_three();
    int acks = 0;
    int ec;
    logic [DW-1:0] e;
    m0_req = 1; m0_we = 0; m0_addr = 8'h30;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ref_mem[8'h30]); cyc_q.push_back(2 * (i + 1));
    end
    for (int k = 1; k <= 12 && acks < 3; k++) begin
      @(negedge clk);
      n_vec++;
      if (m1_ack !== 1'b0) begin n_err++; $display("FAIL hold_m1_ack got %b want 0", m1_ack); end
      if (m0_ack === 1'b1) begin
        acks++;
        e = exp_q.pop_front(); ec = cyc_q.pop_front();
        n_vec++;
        if (m0_rdata !== e) begin n_err++; $display("FAIL hold_rdata got %h want %h", m0_rdata, e); end
        n_vec++;
        if (k != ec) begin n_err++; $display("FAIL hold_cycle got %0d want %0d", k, ec); end
        if (acks == 3) m0_req = 0;
      end
    end
    if (acks != 3) begin n_vec++; n_err++; $display("FAIL hold_timeout got %0d acks want 3", acks); end
    m0_req = 0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || m0_ack !== 1'b0) begin
      n_err++; $display("FAIL hold_extra got busy=%b ack=%b want 0/0", busy, m0_ack);
    end
  endtask

  task automatic test_reset_mid_access();
    m1_req = 1; m1_we = 1; m1_addr = 8'h10; m1_wdata = 16'hBEEF;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b1 || grant_id !== 1'b1) begin
      n_err++; $display("FAIL rsta_busy got busy=%b gid=%b want 1/1", busy, grant_id);
    end
    rst = 1; m1_req = 0;
    #1;
    n_vec++;
    if (ram_we !== 1'b0) begin n_err++; $display("FAIL rsta_we got %b want 0", ram_we); end
    @(negedge clk);
    rst = 0;
    n_vec++;
    if ({m1_ack, busy, grant_id} !== 3'b0) begin
      n_err++; $display("FAIL rsta_state got %b want 000", {m1_ack, busy, grant_id});
    end
    repeat (2) begin
      @(negedge clk);
      n_vec++;
      if (m1_ack !== 1'b0) begin n_err++; $display("FAIL rsta_late_ack got %b want 0", m1_ack); end
    end
    n_vec++;
    if (mem[8'h10] !== ref_mem[8'h10]) begin
      n_err++; $display("FAIL rsta_mem got %h want %h", mem[8'h10], ref_mem[8'h10]);
    end
    idle_inputs();
  endtask

  task automatic test_addr_change();
    logic seen = 0;
    logic [DW-1:0] e;
    m0_req = 1; m0_we = 0; m0_addr = 8'h01;
    exp_q.push_back(ref_mem[8'h01]);
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        m0_addr = 8'h02;
        #1;
        n_vec++;
        if (ram_addr !== 8'h01) begin n_err++; $display("FAIL chg_addr got %h want 01", ram_addr); end
      end
      if (m0_ack === 1'b1) begin
        seen = 1; m0_req = 0;
        e = exp_q.pop_front();
        n_vec++;
        if (m0_rdata !== e) begin n_err++; $display("FAIL chg_rdata got %h want %h", m0_rdata, e); end
      end
    end
    if (!seen) begin n_vec++; n_err++; $display("FAIL chg_timeout got no m0_ack want ack"); end
    m0_req = 0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst  = 1;
    load = 1;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i[7:0]);
    @(negedge clk);
    load = 0;
    test_reset();
    test_single_read();
    test_write_then_read();
    test_contention();
    test_hold_three();
    test_reset_mid_access();
    test_addr_change();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_port_b_arbiter.md
Name: ram_port_b_arbiter

Overview:
- Shares the data port (port B) of the 256x16 program/data RAM between two masters.
- m0 is the CPU load/store path; m1 is the debug/program loader.
- Registers each winning command, drives one RAM access cycle, then returns an ack pulse with registered read data.
- Round-robin on contention; sits between the CPU and loader and the RAM's port B. Port A (instruction fetch) is untouched.

Parameters:
- ADDR_W, 8, RAM address width
- DATA_W, 16, RAM data width

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- m0_req  input  1  CPU request; held with command until m0_ack
- m0_we  input  1  CPU write (1) / read (0)
- m0_addr  input  ADDR_W  CPU address
- m0_wdata  input  DATA_W  CPU write data
- m0_ack  output  1  one-cycle completion pulse to CPU
- m0_rdata  output  DATA_W  CPU read data, valid while m0_ack=1
- m1_req, m1_we, m1_addr, m1_wdata  inputs  1/1/ADDR_W/DATA_W  loader command, same rules as m0
- m1_ack  output  1  loader completion pulse
- m1_rdata  output  DATA_W  loader read data, valid while m1_ack=1
- ram_we  output  1  to RAM port B write enable
- ram_addr  output  ADDR_W  to RAM port B address
- ram_wdata  output  DATA_W  to RAM port B write data
- ram_rdata  input  DATA_W  from RAM port B (combinational read)
- busy  output  1  high while state=ACCESS
- grant_id  output  1  master owning the current/last access (0=m0, 1=m1)

Behaviour:
- Clocking and reset: one clock, clk; rst is synchronous, active-high.
- Reset values:
  - state=IDLE.
  - ram_we=0, ram_addr=0, ram_wdata=0.
  - m0_ack=m1_ack=0, m0_rdata=m1_rdata=0.
  - busy=0, grant_id=0.
  - last_grant=1, so m0 wins the first tie.
- FSM has two states: IDLE and ACCESS.
- IDLE:
  - If any req is high, pick a winner, latch its we/addr/wdata into cmd registers, set grant_id, set last_grant=winner, go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - Only one requesting: that master wins.
  - Both requesting: the master != last_grant wins (strict alternation).
- ACCESS (exactly 1 cycle):
  - ram_addr and ram_wdata come from the cmd registers.
  - ram_we = we_q & ~rst; the write commits at the end of this cycle.
  - At the end of the cycle: winner's rdata register <= ram_rdata (reads only; writes leave rdata unchanged), winner's ack <= 1, state <= IDLE.
- Timing:
  - Latency is 2 cycles: req sampled at edge N, ACCESS during cycle N..N+1, ack high in cycle N+1..N+2.
  - Throughput is one access per 2 cycles. The ack cycle is also an IDLE cycle, so arbitration continues back-to-back.
- ack is high for exactly 1 cycle. The non-winner's ack stays 0.
- A req still high during its own ack cycle counts as a new request and competes normally.
- Masters must hold command fields stable from req rise to ack. Only the values sampled in IDLE are used, so later changes have no effect on the access in flight.
- ram_addr and ram_wdata hold their last values in IDLE. ram_we=0 in IDLE.
- Reset mid-ACCESS: ram_we forced 0 in that cycle (no write), no ack is issued, state returns to IDLE.
- Read-after-write to the same address by the next access returns the new data.
- Addresses wrap naturally within ADDR_W. No range checks.

Decomposition:
- Shared header ram_arb_defs.vh:
  - state encodings ST_IDLE=1'b0, ST_ACCESS=1'b1
  - master ids MID_CPU=1'b0, MID_LOADER=1'b1
  - ADDR_W/DATA_W defaults shared with the RAM
- Sub-module rr_arb2: 2-input round-robin picker. Inputs req[1:0] and last_grant; outputs gnt_valid and gnt_id. Purely combinational; last_grant is stored in the parent.

Test Plan:
- Reset, then m0 read @0x80 (RAM preloaded with 0x000A) -> after reset all outputs 0; m0_ack 2 cycles after req, m0_rdata=0x000A; m1_ack stays 0.
- m1 write 0x1234 @0xFF, then m0 read @0xFF -> ram_we high for exactly 1 cycle with ram_addr=0xFF; m0_rdata=0x1234.
- m0 and m1 both request reads continuously from the cycle after reset -> ack order m0,m1,m0,m1; grant_id alternates; one ack every 2 cycles.
- m0 holds req for 3 accesses while m1 stays idle -> 3 m0_acks at cycles 2, 4, 6; no starvation logic interferes.
- m1 write 0xBEEF @0x10 with rst asserted during its ACCESS cycle -> ram_we stays 0; mem[0x10] unchanged; no m1_ack; state returns to IDLE.
- m0 changes m0_addr from 0x01 to 0x02 during ACCESS -> the access uses 0x01; m0_rdata equals mem[0x01].
